// File: rtl/ps2_tx_serializer.sv
//------------------------------------------------------------------------------
// Module      : ps2_tx_serializer
// Description : PS/2 host-to-device transmit serializer. It builds the frame
//               (start, data LSB first, parity, stop), shifts it out on each
//               PsClkFall strobe and then samples the device acknowledge bit.
//               Optional stall watchdog: define PS2_TX_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ps2_tx_serializer #(
  parameter int DATA_BITS      = 8,
  parameter int PARITY_ODD     = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Write,
  input  logic [DATA_BITS-1:0] Data,
  input  logic                 PsClkFall,
  input  logic                 PsDataIn,
  output logic                 Q,
  output logic                 Busy,
  output logic                 Done,
  output logic                 AckErr,
  output logic                 Timeout
);

  localparam int FRAME_BITS = DATA_BITS + 3;
  localparam int IDX_W      = $clog2(FRAME_BITS);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(FRAME_BITS - 1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_shift = 2'd1;
  localparam logic [1:0] c_st_ack   = 2'd2;

  logic [1:0]            r_state;
  logic [FRAME_BITS-1:0] r_frame;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_q;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ack_err;

  logic                  w_parity;
  logic [FRAME_BITS-1:0] w_frame;
  logic [IDX_W-1:0]      w_next_idx;
  logic                  w_abort;

  assign w_parity   = (^Data) ^ (PARITY_ODD != 0);
  assign w_frame    = {1'b1, w_parity, Data, 1'b0};
  assign w_next_idx = r_idx + 1'b1;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  // A fall on the terminal cycle takes priority over the abort.
  assign w_abort = r_busy && !PsClkFall && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (!r_busy || PsClkFall || Write || w_abort) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_abort;
    end
  end

  assign Timeout = r_timeout;
`else
  assign w_abort = 1'b0;
  assign Timeout = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= c_st_idle;
      r_frame   <= '0;
      r_idx     <= '0;
      r_q       <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (Write) begin
            r_frame   <= w_frame;
            r_idx     <= '0;
            r_q       <= 1'b0;
            r_busy    <= 1'b1;
            r_ack_err <= 1'b0;
            r_state   <= c_st_shift;
          end
        end
        c_st_shift: begin
          if (PsClkFall) begin
            if (r_idx == c_last_idx) begin
              r_q     <= 1'b1;
              r_state <= c_st_ack;
            end else begin
              r_idx <= w_next_idx;
              r_q   <= r_frame[w_next_idx];
            end
          end
        end
        c_st_ack: begin
          if (PsClkFall) begin
            r_done    <= 1'b1;
            r_ack_err <= PsDataIn;
            r_busy    <= 1'b0;
            r_state   <= c_st_idle;
          end
        end
        default: begin
          r_q     <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= c_st_idle;
        end
      endcase

      if (w_abort) begin
        r_q     <= 1'b1;
        r_busy  <= 1'b0;
        r_state <= c_st_idle;
      end
    end
  end

  assign Q      = r_q;
  assign Busy   = r_busy;
  assign Done   = r_done;
  assign AckErr = r_ack_err;

endmodule

`default_nettype wire
